// File: rtl/mopshub_bus_test_seq.sv
// rtl/mopshub_bus_test_seq.sv - per-bus RX/TX test sequencer for MOPSHUB CAN buses
// Optional custom-message (ADV) phase after TX is enabled by defining MOPSHUB_SEQ_ADV_TEST_EN.
`timescale 1ns/1ps
module mopshub_bus_test_seq #(
  parameter int N_BUSES        = 32,
  parameter int BUS_W          = 5,
  parameter int GAP_CYCLES     = 120,
  parameter int ENDWAIT_CYCLES = 1,
  parameter int TO_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_BUSES-1:0] bus_mask,
  input  logic               end_power_init,
  input  logic               sign_on,
  input  logic               rx_done,
  input  logic               tx_done,
  input  logic               adv_done,
  output logic               osc_trim_en,
  output logic               test_rx,
  output logic               test_tx,
  output logic               test_adv,
  output logic               endwait_all,
  output logic [BUS_W-1:0]   bus_sel,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic [BUS_W-1:0]   err_bus,
  output logic [BUS_W:0]     pass_cnt,
  output logic [BUS_W:0]     fail_cnt
);

  localparam int PH_MAX = (GAP_CYCLES > ENDWAIT_CYCLES) ? GAP_CYCLES : ENDWAIT_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = (TO_W > PH_W) ? TO_W : PH_W;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((2 ** TO_W) - 2);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EW_LAST  = CNT_W'(ENDWAIT_CYCLES - 1);
  localparam logic [BUS_W:0]   CNT_MAX  = (BUS_W + 1)'(N_BUSES);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_SIGNON, S_RX, S_ENDW, S_GAP, S_TX, S_ADV, S_NEXT, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [N_BUSES-1:0]   mask_q;
  logic [BUS_W:0]       start_hit, next_hit;
  logic                 to_hit, pass_inc, fail_inc, fatal_to;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [BUS_W:0] first_set(input logic [N_BUSES-1:0] m, input int from);
    logic [BUS_W:0] r;
    r = '0;
    for (int i = N_BUSES - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, BUS_W'(i)};
    end
    return r;
  endfunction

  assign start_hit = first_set(bus_mask, 0);
  assign next_hit  = first_set(mask_q, int'(bus_sel) + 1);
  assign to_hit    = (cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    pass_inc  = 1'b0;
    fail_inc  = 1'b0;
    fatal_to  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = start_hit[BUS_W] ? S_PWR : S_DONE;
      S_PWR: begin
        if (end_power_init) state_nxt = S_SIGNON;
        else if (to_hit) begin state_nxt = S_DONE; fatal_to = 1'b1; end
      end
      S_SIGNON: begin
        if (sign_on) state_nxt = S_RX;
        else if (to_hit) begin state_nxt = S_DONE; fatal_to = 1'b1; end
      end
      S_RX: begin
        if (rx_done) state_nxt = S_ENDW;
        else if (to_hit) begin state_nxt = S_NEXT; fail_inc = 1'b1; end
      end
      S_ENDW:   if (cnt == EW_LAST) state_nxt = S_GAP;
      S_GAP:    if (cnt == GAP_LAST) state_nxt = S_TX;
      S_TX: begin
        // A done input seen together with the timeout still counts as a pass.
        if (tx_done) begin
`ifdef MOPSHUB_SEQ_ADV_TEST_EN
          state_nxt = S_ADV;
`else
          state_nxt = S_NEXT;
          pass_inc  = 1'b1;
`endif
        end else if (to_hit) begin
          state_nxt = S_NEXT;
          fail_inc  = 1'b1;
        end
      end
`ifdef MOPSHUB_SEQ_ADV_TEST_EN
      S_ADV: begin
        if (adv_done) begin state_nxt = S_NEXT; pass_inc = 1'b1; end
        else if (to_hit) begin state_nxt = S_NEXT; fail_inc = 1'b1; end
      end
`endif
      S_NEXT:   state_nxt = next_hit[BUS_W] ? S_RX : S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mask_q      <= '0;
      osc_trim_en <= 1'b0;
      test_rx     <= 1'b0;
      test_tx     <= 1'b0;
      endwait_all <= 1'b0;
      bus_sel     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_bus     <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= (state_nxt != state) ? '0 : cnt + 1'b1;
      osc_trim_en <= (state == S_PWR);
      test_rx     <= (state == S_RX);
      test_tx     <= (state == S_TX);
      endwait_all <= (state == S_ENDW);
      done        <= (state == S_DONE);
      if (state == S_DONE) busy <= 1'b0;
      if (state == S_IDLE && start) begin
        mask_q      <= bus_mask;
        bus_sel     <= start_hit[BUS_W-1:0];
        busy        <= 1'b1;
        err_timeout <= 1'b0;
        err_bus     <= '0;
        pass_cnt    <= '0;
        fail_cnt    <= '0;
      end
      if (state == S_NEXT && next_hit[BUS_W]) bus_sel <= next_hit[BUS_W-1:0];
      if (pass_inc && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      if (fail_inc) begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
        err_timeout <= 1'b1;
        if (!err_timeout) err_bus <= bus_sel;
      end
      if (fatal_to) begin
        err_timeout <= 1'b1;
        err_bus     <= bus_sel;
      end
    end
  end

`ifdef MOPSHUB_SEQ_ADV_TEST_EN
  always_ff @(posedge clk) begin
    if (rst) test_adv <= 1'b0;
    else     test_adv <= (state == S_ADV);
  end
`else
  logic unused_adv;
  assign unused_adv = adv_done;
  assign test_adv   = 1'b0;
`endif

endmodule

// File: tb/tb_mopshub_bus_test_seq.sv
// tb/tb_mopshub_bus_test_seq.sv - directed self-checking bench for mopshub_bus_test_seq
`timescale 1ns/1ps
module tb_mopshub_bus_test_seq;

  logic       clk = 1'b0;
  logic       rst, start, end_power_init, sign_on, rx_done, tx_done, adv_done;
  logic [3:0] bus_mask;
  logic       osc_trim_en, test_rx, test_tx, test_adv, endwait_all, busy, done, err_timeout;
  logic [1:0] bus_sel, err_bus;
  logic [2:0] pass_cnt, fail_cnt;

  mopshub_bus_test_seq #(
    .N_BUSES(4), .BUS_W(2), .GAP_CYCLES(120), .ENDWAIT_CYCLES(1), .TO_W(6)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus_mask(bus_mask),
    .end_power_init(end_power_init), .sign_on(sign_on), .rx_done(rx_done),
    .tx_done(tx_done), .adv_done(adv_done), .osc_trim_en(osc_trim_en),
    .test_rx(test_rx), .test_tx(test_tx), .test_adv(test_adv),
    .endwait_all(endwait_all), .bus_sel(bus_sel), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_bus(err_bus), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor and responder state, written only by the negedge process.
  int cyc = 0, start_cyc = 0, done_cyc = 0, rx_done_cyc = 0;
  int done_pulses = 0, ew_pulses = 0, ew_bad = 0, ew_len = 0, osc_rises = 0, tx_len = 0;
  int pwr_cd = 0, sgn_cd = 0, rx_cd = 0, tx_cd = 0;
  int rx_buses[$];
  int gaps[$];
  int tx_widths[$];
  logic osc_q = 0, rx_q = 0, tx_q = 0, ew_q = 0;

  // Knobs, written only by the main sequence.
  int skip_bus   = -1;
  bit no_sign_on = 0;

  always @(negedge clk) begin
    cyc++;
    if (start) start_cyc = cyc;
    if (done) begin done_pulses++; done_cyc = cyc; end
    if (osc_trim_en && !osc_q) osc_rises++;
    if (test_rx && !rx_q) rx_buses.push_back(int'(bus_sel));
    if (test_tx && !tx_q) begin gaps.push_back(cyc - rx_done_cyc); tx_len = 0; end
    if (test_tx) tx_len++;
    if (!test_tx && tx_q) tx_widths.push_back(tx_len);
    if (endwait_all) ew_len++;
    else if (ew_q) begin ew_pulses++; if (ew_len != 1) ew_bad++; ew_len = 0; end

    end_power_init = 0; sign_on = 0; rx_done = 0; tx_done = 0;
    if (rst) begin
      pwr_cd = 0; sgn_cd = 0; rx_cd = 0; tx_cd = 0;
    end else begin
      if (sgn_cd > 0) begin sgn_cd--; if (sgn_cd == 0) sign_on = 1; end
      if (pwr_cd > 0) begin
        pwr_cd--;
        if (pwr_cd == 0) begin end_power_init = 1; if (!no_sign_on) sgn_cd = 5; end
      end
      if (rx_cd > 0) begin rx_cd--; if (rx_cd == 0) begin rx_done = 1; rx_done_cyc = cyc; end end
      if (tx_cd > 0) begin tx_cd--; if (tx_cd == 0) tx_done = 1; end
      if (osc_trim_en && !osc_q) pwr_cd = 5;
      if (test_rx && !rx_q) rx_cd = 5;
      if (test_tx && !tx_q && int'(bus_sel) != skip_bus) tx_cd = 5;
    end
    osc_q = osc_trim_en; rx_q = test_rx; tx_q = test_tx; ew_q = endwait_all;
  end

  int rx0, g0, w0, d0, e0, eb0, o0;

  function automatic int bus_code(input int from);
    int c = 0;
    for (int i = from; i < rx_buses.size(); i++) c = c * 16 + rx_buses[i];
    return c;
  endfunction

  task automatic snap();
    rx0 = rx_buses.size(); g0 = gaps.size(); w0 = tx_widths.size();
    d0 = done_pulses; e0 = ew_pulses; eb0 = ew_bad; o0 = osc_rises;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    @(posedge clk); #1 bus_mask = m; start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check_eq(tag, 32'(seen), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; start = 0; bus_mask = 0; adv_done = 0;
    end_power_init = 0; sign_on = 0; rx_done = 0; tx_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", 32'({osc_trim_en, test_rx, test_tx, test_adv, endwait_all, busy, done, err_timeout}), 0);
    check_eq("rst_cnts", 32'({bus_sel, err_bus, pass_cnt, fail_cnt}), 0);
    rst = 0;

    // All four buses enabled, every phase answered.
    snap();
    pulse_start(4'b1111);
    wait_done("all_done_seen");
    check_eq("all_order", 32'(bus_code(rx0)), 32'h0123);
    check_eq("all_pass", 32'(pass_cnt), 4);
    check_eq("all_fail", 32'(fail_cnt), 0);
    check_eq("all_err", 32'(err_timeout), 0);
    check_eq("all_done_pulses", 32'(done_pulses - d0), 1);
    check_eq("all_ew_pulses", 32'(ew_pulses - e0), 4);
    check_eq("all_ew_width", 32'(ew_bad - eb0), 0);
    check_eq("all_rx_to_tx", 32'(gaps[g0]), 123);
    check_eq("all_busy_end", 32'(busy), 0);

    // Sparse mask.
    snap();
    pulse_start(4'b1010);
    wait_done("sparse_done_seen");
    check_eq("sparse_order", 32'(bus_code(rx0)), 32'h13);
    check_eq("sparse_n", 32'(rx_buses.size() - rx0), 2);
    check_eq("sparse_pass", 32'(pass_cnt), 2);
    check_eq("sparse_ew_pulses", 32'(ew_pulses - e0), 2);

    // Empty mask.
    snap();
    pulse_start(4'b0000);
    wait_done("empty_done_seen");
    check_eq("empty_latency", 32'(done_cyc - start_cyc), 2);
    check_eq("empty_no_pwr", 32'(osc_rises - o0), 0);
    check_eq("empty_cnts", 32'({pass_cnt, fail_cnt}), 0);
    check_eq("empty_no_rx", 32'(rx_buses.size() - rx0), 0);

    // Bus 2 never answers TX.
    snap();
    skip_bus = 2;
    pulse_start(4'b1111);
    wait_done("to_done_seen");
    skip_bus = -1;
    check_eq("to_tx_width", 32'(tx_widths[w0 + 2]), 63);
    check_eq("to_err", 32'(err_timeout), 1);
    check_eq("to_err_bus", 32'(err_bus), 2);
    check_eq("to_fail", 32'(fail_cnt), 1);
    check_eq("to_pass", 32'(pass_cnt), 3);
    check_eq("to_order", 32'(bus_code(rx0)), 32'h0123);

    // Sign-on never arrives.
    snap();
    no_sign_on = 1;
    pulse_start(4'b1111);
    wait_done("son_done_seen");
    no_sign_on = 0;
    check_eq("son_err", 32'(err_timeout), 1);
    check_eq("son_err_bus", 32'(err_bus), 0);
    check_eq("son_no_rx", 32'(rx_buses.size() - rx0), 0);
    check_eq("son_cnts", 32'({pass_cnt, fail_cnt}), 0);
    check_eq("son_done_pulses", 32'(done_pulses - d0), 1);

    // Reset during TX of bus 1, then restart with a stray start while busy.
    begin
      bit hit = 0;
      pulse_start(4'b1111);
      for (int i = 0; i < 4000 && !hit; i++) begin
        @(posedge clk); #1;
        if (test_tx && bus_sel == 2'd1) hit = 1;
      end
      check_eq("rst_reach_tx1", 32'(hit), 1);
      d0 = done_pulses;
      rst = 1;
      @(posedge clk); #1;
      check_eq("mid_rst_outs", 32'({osc_trim_en, test_rx, test_tx, endwait_all, busy, done, bus_sel}), 0);
      check_eq("mid_rst_cnts", 32'({pass_cnt, fail_cnt, err_timeout}), 0);
      rst = 0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("mid_rst_no_done", 32'(done_pulses - d0), 0);
    end
    snap();
    pulse_start(4'b1111);
    begin
      bit act = 0;
      for (int i = 0; i < 200 && !act; i++) begin
        @(posedge clk); #1;
        if (test_rx) act = 1;
      end
      check_eq("restart_rx_seen", 32'(act), 1);
    end
    pulse_start(4'b0001);
    wait_done("restart_done_seen");
    check_eq("restart_order", 32'(bus_code(rx0)), 32'h0123);
    check_eq("restart_n", 32'(rx_buses.size() - rx0), 4);
    check_eq("restart_pass", 32'(pass_cnt), 4);
    check_eq("restart_done_pulses", 32'(done_pulses - d0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mopshub_bus_test_seq.md
Name: mopshub_bus_test_seq

Overview:
- Synthesisable, parametrised test sequencer that drives per-bus RX/TX test phases across N CAN buses of a MOPSHUB instance.
- Sequences power-init/oscillator-trim, sign-on wait, RX test, end-wait pulse, inter-phase gap and TX test for each enabled bus.
- Adds a per-bus enable mask, phase timeouts and pass/fail accounting.
- Sits beside the MOPSHUB core and data generator; its outputs replace hand-driven test controls.

Parameters:
- N_BUSES, 32, number of CAN buses sequenced (1..32).
- BUS_W, 5, width of bus index; 2**BUS_W >= N_BUSES.
- GAP_CYCLES, 120, idle cycles between RX end and TX start (3 us at 40 MHz); must be >= 1.
- ENDWAIT_CYCLES, 1, width of endwait_all pulse in cycles; must be >= 1.
- TO_W, 16, timeout counter width; phase timeout = 2**TO_W-1 cycles.

Ports:
- clk  in  1  system clock (40 MHz domain).
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; starts a sequence when idle.
- bus_mask  in  N_BUSES  bus enables; sampled at accepted start.
- end_power_init  in  1  power/trim initialisation complete.
- sign_on  in  1  MOPSHUB sign-on complete.
- rx_done  in  1  RX test of current bus finished (pulse).
- tx_done  in  1  TX test of current bus finished (pulse).
- adv_done  in  1  custom-message test finished (used only with the optional feature).
- osc_trim_en  out  1  oscillator auto-trim request.
- test_rx  out  1  RX test active.
- test_tx  out  1  TX test active.
- test_adv  out  1  custom-message test active (constant 0 without the optional feature).
- endwait_all  out  1  end-wait pulse to the hub.
- bus_sel  out  BUS_W  index of bus under test.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- err_timeout  out  1  sticky; at least one phase timed out.
- err_bus  out  BUS_W  bus index of the first timeout.
- pass_cnt  out  BUS_W+1  buses that completed all phases.
- fail_cnt  out  BUS_W+1  buses aborted by timeout.

Behaviour:
- Reset: all outputs 0; state IDLE; mask register, counters and timeout counter cleared. Reset mid-sequence aborts immediately with no done pulse.
- Registered state machine; all outputs are registered and decoded from state/counters.
- IDLE: on start, latch bus_mask, clear err_timeout, err_bus, pass_cnt and fail_cnt, and set busy.
  - mask==0: go to DONE.
  - Otherwise: bus_sel = lowest enabled index, go to PWR.
- start while busy is ignored.
- PWR: osc_trim_en=1 until end_power_init=1, then go to SIGNON. Entered once per sequence.
- SIGNON: wait for sign_on=1, then go to RX.
- RX: test_rx=1 until rx_done, then go to ENDW.
- ENDW: endwait_all=1 for ENDWAIT_CYCLES, then go to GAP.
- GAP: count GAP_CYCLES, then go to TX.
- TX: test_tx=1 until tx_done; pass_cnt+1 (ADV instead when the optional feature is enabled); then go to NEXT.
- NEXT (1 cycle): bus_sel = next higher enabled index, then go to RX. If none remains, go to DONE. No wrap-around.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Phase transitions occur on the cycle after the qualifying input is seen; test_rx/test_tx deassert on that same transition.
- Timeout: counter resets on every state entry.
  - In RX/TX/ADV, reaching 2**TO_W-1 deasserts the active test. fail_cnt+1; err_timeout=1; err_bus is written only on the first timeout. Then go to NEXT.
  - In PWR/SIGNON, a timeout sets err_timeout, sets err_bus=bus_sel, and goes to DONE.
- Done and timeout in the same cycle: done wins and counts as a pass.
- pass_cnt and fail_cnt saturate at N_BUSES. Error and count outputs hold until the next accepted start.

Optional Feature:
- Macro MOPSHUB_SEQ_ADV_TEST_EN.
- Defined: state ADV follows TX. test_adv=1 until adv_done (timeout rules apply); pass_cnt increments after ADV rather than after TX.
- Undefined: no ADV state; test_adv tied to 0; adv_done ignored.

Test Plan:
- N_BUSES=4, mask=4'b1111, all done inputs answered 5 cycles after request -> bus_sel sequence 0,1,2,3; pass_cnt=4; fail_cnt=0; one done pulse; exactly 4 endwait_all pulses of 1 cycle; rx_done to test_tx rise = 1+1+120+1 cycles.
- mask=4'b1010 -> only buses 1 and 3 tested; pass_cnt=2.
- mask=0 -> done 2 cycles after start; PWR not entered; counters 0.
- TO_W=6, bus 2 never raises tx_done -> test_tx drops after 63 cycles; err_timeout=1; err_bus=2; fail_cnt=1; pass_cnt=3; sequence continues to bus 3.
- sign_on never asserted, TO_W=6 -> done pulse after timeout; err_timeout=1; test_rx never asserted.
- rst=1 during TX of bus 1 -> next cycle all outputs 0, no done; a following start restarts from bus 0 with counters cleared. A second start issued while busy is ignored.
